ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem.sv | 84 ++++++++
 tb/tb_ex_mem.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: one-cycle latency, bubble insertion on flush, hold on stall.
// Control bits are qualified by valid_in so an invalid slot can never write state.
module ex_mem #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] alu_result_in,
  input  logic             z_in,
  input  logic [WIDTH-1:0] store_data_in,
  input  logic [WIDTH-1:0] branch_target_in,
  input  logic [RA_W-1:0]  rd_in,
  input  logic             branch_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             reg_write_in,
  input  logic             mem_to_reg_in,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] store_data_out,
  output logic [WIDTH-1:0] branch_target_out,
  output logic [RA_W-1:0]  rd_out,
  output logic             z_out,
  output logic             valid_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic             reg_write_out,
  output logic             mem_to_reg_out,
  output logic             pc_src
);

  typedef struct packed {
    logic vld;
    logic pc_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  ctrl_t ctrl_q, ctrl_d;

  // Write beats read when both are requested, keeping the two mutually exclusive.
  always_comb begin
    ctrl_d            = '0;
    ctrl_d.vld        = valid_in;
    ctrl_d.pc_src     = branch_in & z_in & valid_in;
    ctrl_d.mem_write  = mem_write_in & valid_in;
    ctrl_d.mem_read   = mem_read_in & valid_in & ~mem_write_in;
    ctrl_d.reg_write  = reg_write_in & valid_in;
    ctrl_d.mem_to_reg = mem_to_reg_in & valid_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q            <= '0;
      alu_result_out    <= '0;
      store_data_out    <= '0;
      branch_target_out <= '0;
      rd_out            <= '0;
      z_out             <= 1'b0;
    end else if (flush) begin
      ctrl_q <= '0;
    end else if (!stall) begin
      ctrl_q            <= ctrl_d;
      alu_result_out    <= alu_result_in;
      store_data_out    <= store_data_in;
      branch_target_out <= branch_target_in;
      rd_out            <= rd_in;
      z_out             <= z_in;
    end
  end

  assign valid_out      = ctrl_q.vld;
  assign pc_src         = ctrl_q.pc_src;
  assign mem_read_out   = ctrl_q.mem_read;
  assign mem_write_out  = ctrl_q.mem_write;
  assign reg_write_out  = ctrl_q.reg_write;
  assign mem_to_reg_out = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_ex_mem.sv
// Directed-vector bench for ex_mem with hand-computed expectations.
module tb_ex_mem;
  localparam int WIDTH = 32;
  localparam int RA_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall, flush, valid_in, z_in;
  logic [WIDTH-1:0] alu_result_in, store_data_in, branch_target_in;
  logic [RA_W-1:0]  rd_in;
  logic             branch_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic [WIDTH-1:0] alu_result_out, store_data_out, branch_target_out;
  logic [RA_W-1:0]  rd_out;
  logic             z_out, valid_out, mem_read_out, mem_write_out, reg_write_out;
  logic             mem_to_reg_out, pc_src;

  int n_vec = 0;
  int n_bad = 0;

  ex_mem #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_result_in(alu_result_in), .z_in(z_in), .store_data_in(store_data_in),
    .branch_target_in(branch_target_in), .rd_in(rd_in), .branch_in(branch_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .branch_target_out(branch_target_out), .rd_out(rd_out), .z_out(z_out),
    .valid_out(valid_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .pc_src(pc_src)
  );

  always #5 clk = ~clk;

  // {valid, pc_src, mem_read, mem_write, reg_write, mem_to_reg}
  wire [5:0] ctl = {valid_out, pc_src, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out};
  wire [3*WIDTH+RA_W+7-1:0] all_out = {alu_result_out, store_data_out, branch_target_out,
                                       rd_out, z_out, ctl};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    stall = 0; flush = 0; valid_in = 0; z_in = 0;
    alu_result_in = '0; store_data_in = '0; branch_target_in = '0; rd_in = '0;
    branch_in = 0; mem_read_in = 0; mem_write_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
  endtask

  initial begin
    rst = 1'b0;
    clr_in();
    #1;
    check("reset_all_zero", 128'(all_out), 128'h0);
    tick();
    check("reset_holds_over_edge", 128'(all_out), 128'h0);

    // Basic capture
    rst = 1'b1;
    valid_in = 1; alu_result_in = 32'h0000_0005; reg_write_in = 1; rd_in = 5'd8;
    store_data_in = 32'hDEAD_BEEF;
    tick();
    check("cap_alu", 128'(alu_result_out), 128'h5);
    check("cap_rd", 128'(rd_out), 128'd8);
    check("cap_store", 128'(store_data_out), 128'hDEAD_BEEF);
    check("cap_ctl", 128'(ctl), 128'b100010);

    // Taken branch, then a non-branch capture drops pc_src
    clr_in();
    valid_in = 1; branch_in = 1; z_in = 1; branch_target_in = 32'h0040_0020;
    tick();
    check("br_pc_src", 128'(pc_src), 128'h1);
    check("br_target", 128'(branch_target_out), 128'h0040_0020);
    check("br_z", 128'(z_out), 128'h1);
    branch_in = 0;
    tick();
    check("br_pc_src_drop", 128'(pc_src), 128'h0);

    // Stall holds a negative result for three cycles of changing inputs
    clr_in();
    valid_in = 1; alu_result_in = 32'hFFFF_FFFE; rd_in = 5'd0; mem_to_reg_in = 1;
    tick();
    check("ld_neg_alu", 128'(alu_result_out), 128'hFFFF_FFFE);
    check("ld_rd_zero", 128'(rd_out), 128'h0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      valid_in = 0; alu_result_in = 32'h1111_0000 + 32'(i); rd_in = 5'(i + 3);
      tick();
      check("stall_alu", 128'(alu_result_out), 128'hFFFF_FFFE);
      check("stall_ctl", 128'(ctl), 128'b100001);
    end

    // Flush over stall: control bubbles, data holds
    clr_in();
    valid_in = 1; mem_write_in = 1; alu_result_in = 32'h0000_1234;
    tick();
    check("st_mem_write", 128'(ctl), 128'b100100);
    flush = 1; stall = 1; alu_result_in = 32'h9999_9999;
    tick();
    check("flush_ctl", 128'(ctl), 128'b000000);
    check("flush_alu_hold", 128'(alu_result_out), 128'h0000_1234);

    // Invalid instruction masks every control bit
    clr_in();
    valid_in = 0; mem_write_in = 1; reg_write_in = 1; branch_in = 1; z_in = 1;
    mem_read_in = 1; mem_to_reg_in = 1; alu_result_in = 32'h8000_0001;
    tick();
    check("inv_ctl", 128'(ctl), 128'b000000);
    check("inv_alu_passes", 128'(alu_result_out), 128'h8000_0001);

    // Read and write both requested: write wins
    clr_in();
    valid_in = 1; mem_read_in = 1; mem_write_in = 1;
    tick();
    check("rw_conflict", 128'(ctl), 128'b100100);

    // Taken branch held through a stall cycle
    clr_in();
    valid_in = 1; branch_in = 1; z_in = 1; branch_target_in = 32'h0000_00F0;
    tick();
    stall = 1; branch_in = 0;
    tick();
    check("stall_pc_src_hold", 128'(ctl), 128'b110000);

    // Async reset between edges
    #2 rst = 1'b0;
    #1;
    check("async_rst_all_zero", 128'(all_out), 128'h0);
    stall = 0; branch_in = 1;
    tick();
    check("rst_edge_no_effect", 128'(all_out), 128'h0);
    rst = 1'b1;
    clr_in();
    valid_in = 1; reg_write_in = 1; rd_in = 5'd31; alu_result_in = 32'h0BAD_F00D;
    tick();
    check("post_rst_ctl", 128'(ctl), 128'b100010);
    check("post_rst_alu", 128'(alu_result_out), 128'h0BAD_F00D);
    check("post_rst_rd", 128'(rd_out), 128'd31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
